// File: rtl/rs_multi.sv
`default_nettype none
// ============================================================================
//  Module   : rs_multi
//  Purpose  : Parametrised reservation station. Holds dispatched ops until
//             both operands are ready, wakes them up from NCDB result
//             broadcast channels, and issues the oldest ready entry over a
//             valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module rs_multi #(
  parameter int DEPTH      = 16,
  parameter int ROB_W      = 4,
  parameter int XLEN       = 32,
  parameter int OP_W       = 11,
  parameter int NCDB       = 2,
  parameter int FULL_SLACK = 1
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    rdy_in,
  input  logic                    rob_clear,
  input  logic                    dc_valid,
  input  logic [XLEN-1:0]         dc_pc,
  input  logic [OP_W-1:0]         dc_op,
  input  logic [XLEN-1:0]         dc_imm,
  input  logic                    dc_rdy1,
  input  logic                    dc_rdy2,
  input  logic [ROB_W-1:0]        dc_q1,
  input  logic [ROB_W-1:0]        dc_q2,
  input  logic [XLEN-1:0]         dc_v1,
  input  logic [XLEN-1:0]         dc_v2,
  input  logic [ROB_W-1:0]        dc_dest,
  output logic                    rs_full,
  output logic [$clog2(DEPTH):0]  rs_count,
  input  logic [NCDB-1:0]         cdb_valid,
  input  logic [NCDB*ROB_W-1:0]   cdb_id,
  input  logic [NCDB*XLEN-1:0]    cdb_data,
  output logic                    iss_valid,
  input  logic                    iss_ready,
  output logic [XLEN-1:0]         iss_pc,
  output logic [OP_W-1:0]         iss_op,
  output logic [XLEN-1:0]         iss_imm,
  output logic [XLEN-1:0]         iss_v1,
  output logic [XLEN-1:0]         iss_v2,
  output logic [ROB_W-1:0]        iss_dest,
  output logic                    err_overflow
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_FULL_TH = CNT_W'(DEPTH - FULL_SLACK);

  // Entry storage
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];
  logic [XLEN-1:0]  pc_q  [DEPTH], pc_d  [DEPTH];
  logic [XLEN-1:0]  imm_q [DEPTH], imm_d [DEPTH];
  logic [XLEN-1:0]  v1_q  [DEPTH], v1_d  [DEPTH];
  logic [XLEN-1:0]  v2_q  [DEPTH], v2_d  [DEPTH];
  logic [OP_W-1:0]  op_q  [DEPTH], op_d  [DEPTH];
  logic [ROB_W-1:0] q1_q  [DEPTH], q1_d  [DEPTH];
  logic [ROB_W-1:0] q2_q  [DEPTH], q2_d  [DEPTH];
  logic [ROB_W-1:0] dest_q[DEPTH], dest_d[DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             err_q, err_d;

  logic [DEPTH-1:0] ready_vec;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] free_idx;
  logic             fire;
  logic             disp_acc;
  logic             byp1_hit, byp2_hit;
  logic [XLEN-1:0]  byp1_data, byp2_data;

  // Oldest-ready select: an entry wins when no other ready entry is older
  always_comb begin
    ready_vec = valid_q & rdy1_q & rdy2_q;
    sel_idx   = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (ready_vec[e] && ((older_q[e] & ready_vec) == '0)) sel_idx = IDX_W'(e);
    end
  end

  // Lowest-index free slot, taken from pre-fire occupancy
  always_comb begin
    free_idx = '0;
    for (int e = DEPTH - 1; e >= 0; e--) begin
      if (!valid_q[e]) free_idx = IDX_W'(e);
    end
  end

  // Same-cycle bypass of broadcasts into dispatching operands; lowest channel wins
  always_comb begin
    byp1_hit  = 1'b0;
    byp2_hit  = 1'b0;
    byp1_data = dc_v1;
    byp2_data = dc_v2;
    for (int k = NCDB - 1; k >= 0; k--) begin
      if (!dc_rdy1 && cdb_valid[k] && (cdb_id[k*ROB_W +: ROB_W] == dc_q1)) begin
        byp1_hit  = 1'b1;
        byp1_data = cdb_data[k*XLEN +: XLEN];
      end
      if (!dc_rdy2 && cdb_valid[k] && (cdb_id[k*ROB_W +: ROB_W] == dc_q2)) begin
        byp2_hit  = 1'b1;
        byp2_data = cdb_data[k*XLEN +: XLEN];
      end
    end
  end

  assign iss_valid = rdy_in & (|ready_vec);
  assign fire      = iss_valid & iss_ready & ~rob_clear;
  assign disp_acc  = dc_valid & (count_q < C_DEPTH);

  assign iss_pc       = pc_q[sel_idx];
  assign iss_op       = op_q[sel_idx];
  assign iss_imm      = imm_q[sel_idx];
  assign iss_v1       = v1_q[sel_idx];
  assign iss_v2       = v2_q[sel_idx];
  assign iss_dest     = dest_q[sel_idx];
  assign rs_full      = full_q;
  assign rs_count     = count_q;
  assign err_overflow = err_q;

  // Next-state: flush, wakeup, issue retire, dispatch, occupancy bookkeeping
  always_comb begin
    valid_d = valid_q;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    older_d = older_q;
    pc_d    = pc_q;
    imm_d   = imm_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    op_d    = op_q;
    q1_d    = q1_q;
    q2_d    = q2_q;
    dest_d  = dest_q;
    count_d = count_q;
    full_d  = full_q;
    err_d   = err_q;
    if (rdy_in) begin
      if (rob_clear) begin
        valid_d = '0;
        for (int i = 0; i < DEPTH; i++) older_d[i] = '0;
        count_d = '0;
        full_d  = 1'b0;
      end else begin
        // Descending channel scan so the lowest matching channel is written last
        for (int e = 0; e < DEPTH; e++) begin
          for (int k = NCDB - 1; k >= 0; k--) begin
            if (valid_q[e] && !rdy1_q[e] && cdb_valid[k] &&
                (cdb_id[k*ROB_W +: ROB_W] == q1_q[e])) begin
              rdy1_d[e] = 1'b1;
              v1_d[e]   = cdb_data[k*XLEN +: XLEN];
            end
            if (valid_q[e] && !rdy2_q[e] && cdb_valid[k] &&
                (cdb_id[k*ROB_W +: ROB_W] == q2_q[e])) begin
              rdy2_d[e] = 1'b1;
              v2_d[e]   = cdb_data[k*XLEN +: XLEN];
            end
          end
        end
        if (fire) valid_d[sel_idx] = 1'b0;
        if (disp_acc) begin
          valid_d[free_idx] = 1'b1;
          pc_d[free_idx]    = dc_pc;
          op_d[free_idx]    = dc_op;
          imm_d[free_idx]   = dc_imm;
          rdy1_d[free_idx]  = dc_rdy1 | byp1_hit;
          rdy2_d[free_idx]  = dc_rdy2 | byp2_hit;
          q1_d[free_idx]    = dc_q1;
          q2_d[free_idx]    = dc_q2;
          v1_d[free_idx]    = byp1_data;
          v2_d[free_idx]    = byp2_data;
          dest_d[free_idx]  = dc_dest;
          // Everything already present is older than the new entry
          older_d[free_idx] = valid_q;
          for (int i = 0; i < DEPTH; i++) older_d[i][free_idx] = 1'b0;
        end
        if (dc_valid && !disp_acc) err_d = 1'b1;
        count_d = count_q + CNT_W'(disp_acc) - CNT_W'(fire);
        full_d  = (count_d >= C_FULL_TH);
      end
    end
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      older_q <= older_d;
      count_q <= count_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  // Payload registers; only meaningful while the owning entry is valid
  always_ff @(posedge clk_in) begin
    rdy1_q <= rdy1_d;
    rdy2_q <= rdy2_d;
    pc_q   <= pc_d;
    imm_q  <= imm_d;
    v1_q   <= v1_d;
    v2_q   <= v2_d;
    op_q   <= op_d;
    q1_q   <= q1_d;
    q2_q   <= q2_d;
    dest_q <= dest_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_rs_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rs_multi
//  Purpose  : Directed self-checking bench for rs_multi (default parameters)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rs_multi;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        rob_clear = 1'b0;
  logic        dc_valid = 1'b0;
  logic [31:0] dc_pc = '0;
  logic [10:0] dc_op = '0;
  logic [31:0] dc_imm = '0;
  logic        dc_rdy1 = 1'b0;
  logic        dc_rdy2 = 1'b0;
  logic [3:0]  dc_q1 = '0;
  logic [3:0]  dc_q2 = '0;
  logic [31:0] dc_v1 = '0;
  logic [31:0] dc_v2 = '0;
  logic [3:0]  dc_dest = '0;
  logic        rs_full;
  logic [4:0]  rs_count;
  logic [1:0]  cdb_valid = '0;
  logic [7:0]  cdb_id = '0;
  logic [63:0] cdb_data = '0;
  logic        iss_valid;
  logic        iss_ready = 1'b0;
  logic [31:0] iss_pc;
  logic [10:0] iss_op;
  logic [31:0] iss_imm;
  logic [31:0] iss_v1;
  logic [31:0] iss_v2;
  logic [3:0]  iss_dest;
  logic        err_overflow;

  int tests_run = 0;
  int tests_failed = 0;

  rs_multi dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .dc_valid(dc_valid), .dc_pc(dc_pc), .dc_op(dc_op), .dc_imm(dc_imm),
    .dc_rdy1(dc_rdy1), .dc_rdy2(dc_rdy2), .dc_q1(dc_q1), .dc_q2(dc_q2),
    .dc_v1(dc_v1), .dc_v2(dc_v2), .dc_dest(dc_dest),
    .rs_full(rs_full), .rs_count(rs_count),
    .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_pc(iss_pc), .iss_op(iss_op),
    .iss_imm(iss_imm), .iss_v1(iss_v1), .iss_v2(iss_v2), .iss_dest(iss_dest),
    .err_overflow(err_overflow)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // pc/op/imm are derived from dest so issued fields are predictable
  task automatic set_disp(input logic [3:0] dest, input logic r1, input logic [3:0] q1,
                          input logic [31:0] v1, input logic r2, input logic [3:0] q2,
                          input logic [31:0] v2);
    dc_valid = 1'b1;
    dc_dest  = dest;
    dc_pc    = 32'h1000 + {26'd0, dest, 2'b00};
    dc_op    = {7'd0, dest};
    dc_imm   = {28'd0, dest};
    dc_rdy1  = r1; dc_q1 = q1; dc_v1 = v1;
    dc_rdy2  = r2; dc_q2 = q2; dc_v2 = v2;
  endtask

  task automatic idle_in();
    dc_valid  = 1'b0;
    cdb_valid = '0;
  endtask

  task automatic test_reset();
    #1 rst_n_in = 1'b0;
    #1;
    tests_run++; if (iss_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_iss_valid: got %b expected 0", iss_valid); end
    tests_run++; if (rs_count !== 5'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", rs_count); end
    tests_run++; if (rs_full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %b expected 0", rs_full); end
    tests_run++; if (err_overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", err_overflow); end
    tick();
    rst_n_in = 1'b1;
    tick();
  endtask

  task automatic test_oldest_first();
    iss_ready = 1'b0;
    set_disp(4'd1, 1'b0, 4'd3, 32'h0, 1'b1, 4'd0, 32'h22); tick();
    set_disp(4'd2, 1'b1, 4'd0, 32'hB1, 1'b1, 4'd0, 32'hB2); tick();
    set_disp(4'd3, 1'b1, 4'd0, 32'hC1, 1'b1, 4'd0, 32'hC2); tick();
    idle_in();
    tests_run++; if (rs_count !== 5'd3) begin tests_failed++; $display("FAIL oldest_count: got %0d expected 3", rs_count); end
    tests_run++; if (iss_valid !== 1'b1 || iss_dest !== 4'd2) begin tests_failed++; $display("FAIL oldest_first_B: got v=%b dest=%0d expected v=1 dest=2", iss_valid, iss_dest); end
    tests_run++; if (iss_op !== 11'd2 || iss_v1 !== 32'hB1) begin tests_failed++; $display("FAIL oldest_B_fields: got op=%0d v1=%h expected op=2 v1=b1", iss_op, iss_v1); end
    iss_ready = 1'b1;
    tick();
    tests_run++; if (iss_dest !== 4'd3 || rs_count !== 5'd2) begin tests_failed++; $display("FAIL oldest_second_C: got dest=%0d count=%0d expected dest=3 count=2", iss_dest, rs_count); end
    cdb_valid = 2'b01; cdb_id = {4'd0, 4'd3}; cdb_data = {32'h0, 32'h11};
    tick();
    idle_in();
    tests_run++; if (iss_valid !== 1'b1 || iss_dest !== 4'd1 || iss_v1 !== 32'h11 || iss_v2 !== 32'h22) begin tests_failed++; $display("FAIL oldest_third_A: got v=%b dest=%0d v1=%h v2=%h expected v=1 dest=1 v1=11 v2=22", iss_valid, iss_dest, iss_v1, iss_v2); end
    tick();
    tests_run++; if (iss_valid !== 1'b0 || rs_count !== 5'd0) begin tests_failed++; $display("FAIL oldest_drain: got v=%b count=%0d expected v=0 count=0", iss_valid, rs_count); end
    iss_ready = 1'b0;
  endtask

  task automatic test_age_vs_index();
    set_disp(4'd4, 1'b0, 4'd9, 32'h0, 1'b1, 4'd0, 32'h0); tick();
    set_disp(4'd5, 1'b1, 4'd0, 32'h5, 1'b1, 4'd0, 32'h0); tick();
    set_disp(4'd6, 1'b1, 4'd0, 32'h6, 1'b1, 4'd0, 32'h0); tick();
    // Dispatch W while Y issues: the freed slot is not reused this cycle
    set_disp(4'd7, 1'b1, 4'd0, 32'h7, 1'b1, 4'd0, 32'h0); iss_ready = 1'b1; tick();
    iss_ready = 1'b0; idle_in();
    tests_run++; if (rs_count !== 5'd3 || iss_dest !== 4'd6) begin tests_failed++; $display("FAIL b2b_dispatch_fire: got count=%0d dest=%0d expected count=3 dest=6", rs_count, iss_dest); end
    // V lands in the lower-index hole left by Y but is youngest
    set_disp(4'd8, 1'b1, 4'd0, 32'h8, 1'b1, 4'd0, 32'h0); tick();
    idle_in();
    tests_run++; if (rs_count !== 5'd4 || iss_dest !== 4'd6) begin tests_failed++; $display("FAIL age_Z: got count=%0d dest=%0d expected count=4 dest=6", rs_count, iss_dest); end
    iss_ready = 1'b1; tick();
    tests_run++; if (iss_dest !== 4'd7) begin tests_failed++; $display("FAIL age_W_over_lower_index: got dest=%0d expected 7", iss_dest); end
    tick();
    tests_run++; if (iss_dest !== 4'd8) begin tests_failed++; $display("FAIL age_V: got dest=%0d expected 8", iss_dest); end
    tick();
    tests_run++; if (iss_valid !== 1'b0 || rs_count !== 5'd1) begin tests_failed++; $display("FAIL age_unready_left: got v=%b count=%0d expected v=0 count=1", iss_valid, rs_count); end
    iss_ready = 1'b0;
    rob_clear = 1'b1; tick(); rob_clear = 1'b0;
  endtask

  task automatic test_bypass();
    set_disp(4'd10, 1'b0, 4'd7, 32'h0, 1'b1, 4'd0, 32'h1);
    cdb_valid = 2'b10; cdb_id = {4'd7, 4'd0}; cdb_data = {32'hDEADBEEF, 32'h0};
    tick(); idle_in();
    tests_run++; if (iss_valid !== 1'b1 || iss_v1 !== 32'hDEADBEEF || iss_dest !== 4'd10) begin tests_failed++; $display("FAIL bypass_ch1: got v=%b v1=%h dest=%0d expected v=1 v1=deadbeef dest=10", iss_valid, iss_v1, iss_dest); end
    set_disp(4'd11, 1'b0, 4'd7, 32'h0, 1'b1, 4'd0, 32'h1);
    cdb_valid = 2'b11; cdb_id = {4'd7, 4'd7}; cdb_data = {32'h5678, 32'h1234};
    tick(); idle_in();
    tests_run++; if (rs_count !== 5'd2 || iss_dest !== 4'd10) begin tests_failed++; $display("FAIL bypass_second: got count=%0d dest=%0d expected count=2 dest=10", rs_count, iss_dest); end
    iss_ready = 1'b1; tick();
    tests_run++; if (iss_dest !== 4'd11 || iss_v1 !== 32'h1234) begin tests_failed++; $display("FAIL bypass_lowest_channel: got dest=%0d v1=%h expected dest=11 v1=1234", iss_dest, iss_v1); end
    tick();
    tests_run++; if (rs_count !== 5'd0) begin tests_failed++; $display("FAIL bypass_drain: got count=%0d expected 0", rs_count); end
    iss_ready = 1'b0;
  endtask

  task automatic test_two_channel();
    set_disp(4'd12, 1'b0, 4'd2, 32'h0, 1'b0, 4'd5, 32'h0); tick(); idle_in();
    tests_run++; if (iss_valid !== 1'b0) begin tests_failed++; $display("FAIL two_ch_waiting: got v=%b expected 0", iss_valid); end
    cdb_valid = 2'b11; cdb_id = {4'd2, 4'd5}; cdb_data = {32'h20, 32'h50};
    tick(); idle_in();
    tests_run++; if (iss_valid !== 1'b1 || iss_v1 !== 32'h20 || iss_v2 !== 32'h50) begin tests_failed++; $display("FAIL two_ch_wakeup: got v=%b v1=%h v2=%h expected v=1 v1=20 v2=50", iss_valid, iss_v1, iss_v2); end
    iss_ready = 1'b1; tick(); iss_ready = 1'b0;
    tests_run++; if (rs_count !== 5'd0) begin tests_failed++; $display("FAIL two_ch_issued: got count=%0d expected 0", rs_count); end
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 17; i++) begin
      set_disp(4'(i), 1'b1, 4'd0, 32'(i), 1'b1, 4'd0, 32'h0);
      tick();
      if (i == 13) begin
        tests_run++; if (rs_count !== 5'd14 || rs_full !== 1'b0) begin tests_failed++; $display("FAIL full_at_14: got count=%0d full=%b expected 14 0", rs_count, rs_full); end
      end
      if (i == 14) begin
        tests_run++; if (rs_count !== 5'd15 || rs_full !== 1'b1) begin tests_failed++; $display("FAIL full_at_15: got count=%0d full=%b expected 15 1", rs_count, rs_full); end
      end
      if (i == 15) begin
        tests_run++; if (rs_count !== 5'd16 || err_overflow !== 1'b0) begin tests_failed++; $display("FAIL full_at_16: got count=%0d err=%b expected 16 0", rs_count, err_overflow); end
      end
      if (i == 16) begin
        tests_run++; if (rs_count !== 5'd16 || err_overflow !== 1'b1) begin tests_failed++; $display("FAIL overflow: got count=%0d err=%b expected 16 1", rs_count, err_overflow); end
      end
    end
    idle_in();
    tests_run++; if (iss_dest !== 4'd0 || iss_pc !== 32'h1000) begin tests_failed++; $display("FAIL full_oldest: got dest=%0d pc=%h expected 0 1000", iss_dest, iss_pc); end
    iss_ready = 1'b1; tick(); iss_ready = 1'b0;
    tests_run++; if (rs_count !== 5'd15 || rs_full !== 1'b1 || err_overflow !== 1'b1) begin tests_failed++; $display("FAIL full_after_issue: got count=%0d full=%b err=%b expected 15 1 1", rs_count, rs_full, err_overflow); end
    iss_ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    tests_run++; if (rs_count !== 5'd8 || rs_full !== 1'b0) begin tests_failed++; $display("FAIL drain_to_8: got count=%0d full=%b expected 8 0", rs_count, rs_full); end
  endtask

  task automatic test_flush_and_stall();
    rob_clear = 1'b1; tick(); rob_clear = 1'b0; iss_ready = 1'b0;
    tests_run++; if (rs_count !== 5'd0 || rs_full !== 1'b0 || iss_valid !== 1'b0 || err_overflow !== 1'b1) begin tests_failed++; $display("FAIL flush: got count=%0d full=%b v=%b err=%b expected 0 0 0 1", rs_count, rs_full, iss_valid, err_overflow); end
    set_disp(4'd9, 1'b0, 4'd6, 32'h0, 1'b1, 4'd0, 32'h0); tick(); idle_in();
    rdy_in = 1'b0;
    cdb_valid = 2'b01; cdb_id = {4'd0, 4'd6}; cdb_data = {32'h0, 32'h66};
    tick(); idle_in(); rdy_in = 1'b1;
    tests_run++; if (iss_valid !== 1'b0 || rs_count !== 5'd1) begin tests_failed++; $display("FAIL stall_ignores_cdb: got v=%b count=%0d expected 0 1", iss_valid, rs_count); end
    cdb_valid = 2'b01; tick(); idle_in();
    tests_run++; if (iss_valid !== 1'b1 || iss_v1 !== 32'h66) begin tests_failed++; $display("FAIL wake_after_stall: got v=%b v1=%h expected 1 66", iss_valid, iss_v1); end
    rdy_in = 1'b0; #1;
    tests_run++; if (iss_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_masks_iss: got v=%b expected 0", iss_valid); end
    set_disp(4'd13, 1'b1, 4'd0, 32'h0, 1'b1, 4'd0, 32'h0); tick(); idle_in();
    rdy_in = 1'b1;
    tests_run++; if (rs_count !== 5'd1) begin tests_failed++; $display("FAIL stall_blocks_dispatch: got count=%0d expected 1", rs_count); end
    rob_clear = 1'b1; tick(); rob_clear = 1'b0;
  endtask

  task automatic test_reset_mid();
    iss_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_disp(4'(i), 1'b1, 4'd0, 32'h0, 1'b1, 4'd0, 32'h0);
      tick();
    end
    idle_in();
    tests_run++; if (rs_count !== 5'd5 || iss_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_fill: got count=%0d v=%b expected 5 1", rs_count, iss_valid); end
    #2 rst_n_in = 1'b0;
    #1;
    tests_run++; if (iss_valid !== 1'b0 || rs_count !== 5'd0 || err_overflow !== 1'b0) begin tests_failed++; $display("FAIL async_reset: got v=%b count=%0d err=%b expected 0 0 0", iss_valid, rs_count, err_overflow); end
    #2 rst_n_in = 1'b1;
    tick();
    tests_run++; if (rs_count !== 5'd0 || iss_valid !== 1'b0) begin tests_failed++; $display("FAIL after_reset: got count=%0d v=%b expected 0 0", rs_count, iss_valid); end
  endtask

  initial begin
    test_reset();
    test_oldest_first();
    test_age_vs_index();
    test_bypass();
    test_two_channel();
    test_full_overflow();
    test_flush_and_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
